// File: rtl/parity_frame_checker.sv
// Streaming per-frame parity generator/checker: accumulates parity, ones count
// and beat count over a valid/ready framed word stream and emits one result record per frame.
module parity_frame_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              odd_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              in_par,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_par,
   output logic              out_err,
   output logic [CNT_W-1:0]  out_ones,
   output logic [CNT_W-1:0]  out_beats
);

   localparam int PC_W  = $clog2(DATA_W + 1);
   localparam int SUM_W = CNT_W + PC_W;
   localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

   typedef enum logic {IDLE, ACC} state_t;

   function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] d);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_W; i++) c = c + PC_W'(d[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
      logic [SUM_W-1:0] s;
      s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
      if (s > CNT_MAX) s = CNT_MAX;
      return s[CNT_W-1:0];
   endfunction

   state_t           state_p0, state_nxt;
   logic             mode_p0, mode_nxt;
   logic             par_p0, par_nxt;
   logic [CNT_W-1:0] ones_p0, ones_nxt;
   logic [CNT_W-1:0] beats_p0, beats_nxt;
   logic             accept, load, frame_par;
   logic [PC_W-1:0]  beat_ones;

   logic             vld_p1, par_p1, err_p1;
   logic [CNT_W-1:0] ones_p1, beats_p1;

   assign in_ready  = rst_n & ~clr & (~vld_p1 | out_ready);
   assign accept    = in_valid & in_ready;
   assign load      = accept & in_last;
   assign beat_ones = popcount(in_data);
   assign frame_par = par_nxt ^ mode_nxt;

   always_comb begin
      state_nxt = state_p0;
      mode_nxt  = mode_p0;
      par_nxt   = par_p0;
      ones_nxt  = ones_p0;
      beats_nxt = beats_p0;
      if (clr) begin
         state_nxt = IDLE;
      end else if (accept) begin
         if (state_p0 == IDLE) begin
            mode_nxt  = odd_mode;
            par_nxt   = ^in_data;
            ones_nxt  = sat_add('0, beat_ones);
            beats_nxt = CNT_W'(1);
         end else begin
            par_nxt   = par_p0 ^ (^in_data);
            ones_nxt  = sat_add(ones_p0, beat_ones);
            beats_nxt = sat_add(beats_p0, PC_W'(1));
         end
         state_nxt = in_last ? IDLE : ACC;
      end
   end

   // Stage p0: frame accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= IDLE;
         mode_p0  <= 1'b0;
         par_p0   <= 1'b0;
         ones_p0  <= '0;
         beats_p0 <= '0;
      end else begin
         state_p0 <= state_nxt;
         mode_p0  <= mode_nxt;
         par_p0   <= par_nxt;
         ones_p0  <= ones_nxt;
         beats_p0 <= beats_nxt;
      end
   end

   // Stage p1: result record; a consume and a load in one cycle keeps valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         par_p1   <= 1'b0;
         err_p1   <= 1'b0;
         ones_p1  <= '0;
         beats_p1 <= '0;
      end else if (load) begin
         vld_p1   <= 1'b1;
         par_p1   <= frame_par;
         err_p1   <= frame_par ^ in_par;
         ones_p1  <= ones_nxt;
         beats_p1 <= beats_nxt;
      end else if (out_ready) begin
         vld_p1   <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_par   = par_p1;
   assign out_err   = err_p1;
   assign out_ones  = ones_p1;
   assign out_beats = beats_p1;

endmodule
